// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared phase encoding, widths and default durations for the washer controller
package wm_pkg;
  localparam int PERIOD_W = 4;
  localparam int PHASE_W  = 3;

  typedef enum logic [PHASE_W-1:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4
  } phase_t;

  localparam logic [PERIOD_W-1:0] DEF_FILL_T  = 4'd2;
  localparam logic [PERIOD_W-1:0] DEF_WASH_T  = 4'd5;
  localparam logic [PERIOD_W-1:0] DEF_RINSE_T = 4'd2;
  localparam logic [PERIOD_W-1:0] DEF_SPIN_T  = 4'd1;
endpackage

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - fill/wash/rinse/spin sequencer that arms an external timer per phase
module wash_sequencer
  import wm_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] FILL_T  = DEF_FILL_T,
  parameter logic [PERIOD_W-1:0] WASH_T  = DEF_WASH_T,
  parameter logic [PERIOD_W-1:0] RINSE_T = DEF_RINSE_T,
  parameter logic [PERIOD_W-1:0] SPIN_T  = DEF_SPIN_T
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                door_closed,
  input  logic                pause,
  input  logic                double_wash,
  input  logic                tmr_done,
  output logic                tmr_enable,
  output logic                tmr_clear,
  output logic [PERIOD_W-1:0] tmr_period,
  output logic                fill_valve,
  output logic                motor_on,
  output logic                drain_valve,
  output logic                door_lock,
  output logic                cycle_done,
  output logic [PHASE_W-1:0]  phase
);

  phase_t state;
  logic   arm;
  logic   second_pass_pending;
  logic   held;

  assign held  = (state != IDLE) && (pause || !door_closed);
  assign phase = state;

  // arm marks a fresh phase whose timer has not been cleared yet; a stale
  // tmr_done from the previous phase must not end it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      arm                 <= 1'b0;
      second_pass_pending <= 1'b0;
      cycle_done          <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (state == IDLE) begin
        if (start && door_closed) begin
          state               <= FILL;
          arm                 <= 1'b1;
          second_pass_pending <= double_wash;
        end
      end else if (!held) begin
        if (arm) begin
          arm <= 1'b0;
        end else if (tmr_done) begin
          case (state)
            FILL: begin
              state <= WASH;
              arm   <= 1'b1;
            end
            WASH: begin
              state <= RINSE;
              arm   <= 1'b1;
            end
            RINSE: begin
              arm <= 1'b1;
              if (second_pass_pending) begin
                state               <= WASH;
                second_pass_pending <= 1'b0;
              end else begin
                state <= SPIN;
              end
            end
            SPIN: begin
              state      <= IDLE;
              cycle_done <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Actuators and timer controls drop while held; the lock stays engaged.
  always_comb begin
    tmr_enable  = 1'b0;
    tmr_clear   = 1'b0;
    tmr_period  = '0;
    fill_valve  = 1'b0;
    motor_on    = 1'b0;
    drain_valve = 1'b0;
    door_lock   = (state != IDLE);
    case (state)
      FILL:    tmr_period = FILL_T;
      WASH:    tmr_period = WASH_T;
      RINSE:   tmr_period = RINSE_T;
      SPIN:    tmr_period = SPIN_T;
      default: tmr_period = '0;
    endcase
    if (state != IDLE && !held) begin
      tmr_enable = 1'b1;
      tmr_clear  = arm;
      case (state)
        FILL:  fill_valve = 1'b1;
        WASH:  motor_on   = 1'b1;
        RINSE: begin
          fill_valve = 1'b1;
          motor_on   = 1'b1;
        end
        SPIN: begin
          motor_on    = 1'b1;
          drain_valve = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
